// File: rtl/fp16_pkg.sv
// Shared FP16 constants, pooling-window geometry, unpool FSM states and slot mux helper.
// Pure definitions: no latency, no flow control.
package fp16_pkg;

  localparam int              FP16_W        = 16;
  localparam logic [15:0]     FP16_POS_ZERO = 16'h0000;
  localparam logic [15:0]     FP16_NEG_ZERO = 16'h8000;
  localparam int              FP16_SIGN_BIT = 15;
  localparam int              POOL_WIN      = 4;
  localparam int              POOL_IDX_W    = 2;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } unpool_state_t;

  // The argmax slot carries the raw bits; every other slot is +0.0, never -0.0.
  function automatic logic [FP16_W-1:0] slot_val(
    input logic [POOL_IDX_W-1:0] pos,
    input logic [POOL_IDX_W-1:0] idx,
    input logic [FP16_W-1:0]     value
  );
    return (pos == idx) ? value : FP16_POS_ZERO;
  endfunction

  function automatic logic is_neg_nonzero(input logic [FP16_W-1:0] value);
    return value[FP16_SIGN_BIT] && (value[FP16_SIGN_BIT-1:0] != '0);
  endfunction

endpackage

// File: rtl/fp16_maxunpool2d_stream_if.sv
// Pooled-beat input stream and unpooled-element output stream for the 2x2 max-unpool stage.
// slave = the unpool block, master = the side driving beats and consuming elements.
interface fp16_maxunpool2d_stream_if;
  import fp16_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  logic [FP16_W-1:0]     in_value;
  logic [POOL_IDX_W-1:0] in_idx;
  logic                  in_last;
  logic                  out_valid;
  logic                  out_ready;
  logic [FP16_W-1:0]     out_data;
  logic [POOL_IDX_W-1:0] out_pos;
  logic                  out_last;

  modport slave (
    input  in_valid, in_value, in_idx, in_last, out_ready,
    output in_ready, out_valid, out_data, out_pos, out_last
  );

  modport master (
    output in_valid, in_value, in_idx, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_pos, out_last
  );
endinterface

// File: rtl/fp16_maxunpool2d_stream.sv
// Expands one pooled FP16 value + argmax index into a serial 2x2 window, one element per cycle.
// First element valid the cycle after acceptance; outputs hold under backpressure, next beat taken in the pos==3 cycle.
module fp16_maxunpool2d_stream
  import fp16_pkg::*;
#(
  parameter int DATA_W = FP16_W,
  parameter int WIN    = POOL_WIN,
  parameter int IDX_W  = POOL_IDX_W
) (
  input  logic                          clk,
  input  logic                          rst_n,
  fp16_maxunpool2d_stream_if.slave      s,
  output logic                          busy,
  output logic                          err_neg
);

  localparam logic [IDX_W-1:0] LAST_POS = IDX_W'(WIN - 1);

  unpool_state_t     r_state;
  logic [IDX_W-1:0]  r_pos;
  logic [DATA_W-1:0] r_value;
  logic [IDX_W-1:0]  r_idx;
  logic              r_last;
  logic              r_err;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic [IDX_W-1:0]  r_out_pos;
  logic              r_out_last;

  logic              w_in_ready;
  logic              w_accept;
  logic [IDX_W-1:0]  w_nxt_pos;

  // The only combinational path: out_ready frees the slot during the final element.
  assign w_in_ready = (r_state == IDLE) ||
                      ((r_state == EMIT) && (r_pos == LAST_POS) && s.out_ready);
  assign w_accept   = s.in_valid && w_in_ready;
  assign w_nxt_pos  = r_pos + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_pos       <= '0;
      r_value     <= '0;
      r_idx       <= '0;
      r_last      <= 1'b0;
      r_err       <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= FP16_POS_ZERO;
      r_out_pos   <= '0;
      r_out_last  <= 1'b0;
    end else if (w_accept) begin
      r_state     <= EMIT;
      r_pos       <= '0;
      r_value     <= s.in_value;
      r_idx       <= s.in_idx;
      r_last      <= s.in_last;
      r_out_valid <= 1'b1;
      r_out_data  <= slot_val('0, s.in_idx, s.in_value);
      r_out_pos   <= '0;
      r_out_last  <= 1'b0;
      if (is_neg_nonzero(s.in_value)) begin
        r_err <= 1'b1;
      end
    end else if ((r_state == EMIT) && s.out_ready) begin
      if (r_pos != LAST_POS) begin
        r_pos      <= w_nxt_pos;
        r_out_data <= slot_val(w_nxt_pos, r_idx, r_value);
        r_out_pos  <= w_nxt_pos;
        r_out_last <= r_last && (w_nxt_pos == LAST_POS);
      end else begin
        r_state     <= IDLE;
        r_pos       <= '0;
        r_out_valid <= 1'b0;
        r_out_data  <= FP16_POS_ZERO;
        r_out_pos   <= '0;
        r_out_last  <= 1'b0;
      end
    end
  end

  assign s.in_ready  = w_in_ready;
  assign s.out_valid = r_out_valid;
  assign s.out_data  = r_out_data;
  assign s.out_pos   = r_out_pos;
  assign s.out_last  = r_out_last;
  assign busy        = (r_state == EMIT);
  assign err_neg     = r_err;

endmodule
